mem_access: RTL and testbench

- Memory access (MA) stage of the riscv-small 5-stage pipeline. Consumes the EX→MA pipeline register outputs and drives the data-memory request/acknowledge bus.
- Performs load formatting: byte/half extraction with sign or zero extension.
- Performs store formatting: byte-lane replication and byte enables.
- Stalls the pipeline while a memory transaction is outstanding.
- Registers the results into the MA→WB pipeline register.

---
 rtl/mem_access.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_access.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory access (MA) stage of the riscv-small 5-stage pipeline.
// Drives the data-memory req/ack bus from the EX->MA register and formats
// load and store data. It holds the pipeline while a transaction is
// outstanding, then captures the result into the MA->WB register.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned
// half/word accesses. This adds the misalign_err and misalign_addr outputs.
module mem_access #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_en,
   input  logic                  flush,
   input  logic [XLEN-1:0]       alu_ma,
   input  logic [XLEN-1:0]       rs2_ma,
   input  logic                  rd0_wr_en_ma,
   input  logic                  data_rd_en_ma,
   input  logic                  data_wr_en_ma,
   input  logic [2:0]            funct3_ma,
   input  logic [REG_ADDR_W-1:0] rd0_addr_ma,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [XLEN-1:0]       dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [XLEN-1:0]       dmem_wdata,
   input  logic [XLEN-1:0]       dmem_rdata,
   input  logic                  dmem_ack,
   output logic                  stall_ma,
   output logic [XLEN-1:0]       rd0_data_wb,
   output logic                  rd0_wr_en_wb,
   output logic [REG_ADDR_W-1:0] rd0_addr_wb
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   ,
   output logic                  misalign_err,
   output logic [XLEN-1:0]       misalign_addr
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Load extraction: the byte is selected by off and the half by off[1].
   // Undefined funct3 codes fall through to a full word.
   function automatic logic [31:0] load_fmt(input logic [2:0]  f3,
                                            input logic [1:0]  off,
                                            input logic [31:0] rdata);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        res;
      case (off)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  res = {{24{b[7]}}, b};
         3'b100:  res = {24'd0, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b101:  res = {16'd0, h};
         default: res = rdata;
      endcase
      return res;
   endfunction

   // Store byte enables: a byte uses its own lane, a half uses the lower or
   // upper pair, and anything else is a full word.
   function automatic logic [3:0] store_be(input logic [2:0] f3,
                                           input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << {off[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data is replicated across every lane so the memory can take the
   // enabled bytes straight from their natural positions.
   function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                              input logic [31:0] rs2);
      logic [31:0] wd;
      case (f3[1:0])
         2'b00:   wd = {4{rs2[7:0]}};
         2'b01:   wd = {2{rs2[15:0]}};
         default: wd = rs2;
      endcase
      return wd;
   endfunction

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   // A half must sit on an even address and a word on a multiple of four.
   // Undefined funct3 codes are treated as words, matching load_fmt.
   function automatic logic is_misaligned(input logic [2:0] f3,
                                          input logic [1:0] off);
      logic mis;
      case (f3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction
`endif

   state_t                  state_q, state_d;
   logic                    req_raw;
   logic                    mem_op;
   logic                    is_store;
   logic                    is_load;
   logic                    mis;
   logic                    access;
   logic [1:0]              off;
   logic [XLEN-1:0]         wb_data_d, wb_data_q;
   logic                    wb_en_d, wb_en_q;
   logic [REG_ADDR_W-1:0]   wb_addr_d, wb_addr_q;
   logic                    err_d, err_q;
   logic [XLEN-1:0]         err_addr_d, err_addr_q;

   assign off      = alu_ma[1:0];
   assign mem_op   = data_rd_en_ma | data_wr_en_ma;
   assign is_store = data_wr_en_ma;
   assign is_load  = data_rd_en_ma & ~data_wr_en_ma;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign mis      = mem_op & is_misaligned(funct3_ma, off);
`else
   assign mis      = 1'b0;
`endif
   assign access   = clk_en & mem_op & ~mis;

   // State register: an abandoned transaction returns to IDLE on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Request generation and next state. The state moves only when clk_en=1,
   // but BUSY keeps the request raised regardless of clk_en.
   always_comb begin
      state_d = state_q;
      req_raw = 1'b0;
      case (state_q)
         IDLE: begin
            req_raw = access;
            if (req_raw && !dmem_ack) state_d = BUSY;
         end
         BUSY: begin
            req_raw = 1'b1;
            if (clk_en && dmem_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Gating the request with rst_n drops it the instant reset asserts,
   // even while the upstream inputs still describe an access.
   assign dmem_req   = rst_n & req_raw;
   assign stall_ma   = dmem_req & ~dmem_ack;
   assign dmem_addr  = {alu_ma[XLEN-1:2], 2'b00};
   assign dmem_we    = dmem_req & is_store;
   assign dmem_be    = dmem_req ? (is_store ? store_be(funct3_ma, off) : 4'b1111)
                                : 4'b0000;
   assign dmem_wdata = (dmem_req && is_store) ? store_data(funct3_ma, rs2_ma)
                                              : '0;

   // WB next state. The priority order is flush, then stall bubble, then
   // misaligned bubble, then load, then store, then ALU pass-through.
   always_comb begin
      wb_data_d  = wb_data_q;
      wb_en_d    = wb_en_q;
      wb_addr_d  = wb_addr_q;
      err_d      = 1'b0;
      err_addr_d = err_addr_q;
      if (clk_en) begin
         if (flush || stall_ma || mis) begin
            wb_data_d = '0;
            wb_en_d   = 1'b0;
            wb_addr_d = '0;
            if (!flush && !stall_ma && mis) begin
               err_d      = 1'b1;
               err_addr_d = alu_ma;
            end
         end else if (is_load) begin
            wb_data_d = load_fmt(funct3_ma, off, dmem_rdata);
            wb_en_d   = rd0_wr_en_ma;
            wb_addr_d = rd0_addr_ma;
         end else if (is_store) begin
            wb_data_d = '0;
            wb_en_d   = 1'b0;
            wb_addr_d = '0;
         end else begin
            wb_data_d = alu_ma;
            wb_en_d   = rd0_wr_en_ma;
            wb_addr_d = rd0_addr_ma;
         end
      end
   end

   // MA->WB pipeline register and misalignment capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_data_q  <= '0;
         wb_en_q    <= 1'b0;
         wb_addr_q  <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         wb_data_q  <= wb_data_d;
         wb_en_q    <= wb_en_d;
         wb_addr_q  <= wb_addr_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign rd0_data_wb  = wb_data_q;
   assign rd0_wr_en_wb = wb_en_q;
   assign rd0_addr_wb  = wb_addr_q;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign misalign_err  = err_q;
   assign misalign_addr = err_addr_q;
`else
   // The error state still exists without the trap but has no port.
   logic unused_err;
   assign unused_err = err_q ^ (^err_addr_q);
`endif

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: table-driven vectors with a WB scoreboard, plus
// hand-written sequences for flush, clock enable and reset corner cases.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clk_en;
   logic        flush;
   logic [31:0] alu_ma;
   logic [31:0] rs2_ma;
   logic        rd0_wr_en_ma;
   logic        data_rd_en_ma;
   logic        data_wr_en_ma;
   logic [2:0]  funct3_ma;
   logic [4:0]  rd0_addr_ma;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        stall_ma;
   logic [31:0] rd0_data_wb;
   logic        rd0_wr_en_wb;
   logic [4:0]  rd0_addr_wb;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   logic        misalign_err;
   logic [31:0] misalign_addr;
`endif

   always #5 clk = ~clk;

   mem_access #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
      .alu_ma(alu_ma), .rs2_ma(rs2_ma), .rd0_wr_en_ma(rd0_wr_en_ma),
      .data_rd_en_ma(data_rd_en_ma), .data_wr_en_ma(data_wr_en_ma),
      .funct3_ma(funct3_ma), .rd0_addr_ma(rd0_addr_ma),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .stall_ma(stall_ma), .rd0_data_wb(rd0_data_wb),
      .rd0_wr_en_wb(rd0_wr_en_wb), .rd0_addr_wb(rd0_addr_wb)
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      , .misalign_err(misalign_err), .misalign_addr(misalign_addr)
`endif
   );

   typedef struct {
      logic [31:0] alu;
      logic [31:0] rs2;
      logic        rd_en;
      logic        wr_en;
      logic [2:0]  f3;
      logic        rwe;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          dly;
      logic        e_req;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_wbd;
      logic        e_wbe;
      logic        chk_d;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        en;
      logic [4:0]  a;
      logic        chk_d;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      clk_en = 1'b1; flush = 1'b0; alu_ma = '0; rs2_ma = '0;
      rd0_wr_en_ma = 1'b0; data_rd_en_ma = 1'b0; data_wr_en_ma = 1'b0;
      funct3_ma = 3'b000; rd0_addr_ma = '0; dmem_rdata = '0; dmem_ack = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      exp_t e;
      @(negedge clk);
      idle_inputs();
      alu_ma = v.alu; rs2_ma = v.rs2; data_rd_en_ma = v.rd_en;
      data_wr_en_ma = v.wr_en; funct3_ma = v.f3; rd0_wr_en_ma = v.rwe;
      rd0_addr_ma = v.rd;
      dmem_ack   = (v.dly == 0);
      dmem_rdata = (v.dly == 0) ? v.rdata : 32'h0;
      #1;
      chk({nm, ".req"}, {31'd0, dmem_req}, {31'd0, v.e_req});
      chk({nm, ".stall"}, {31'd0, stall_ma}, {31'd0, (v.e_req && v.dly != 0)});
      chk({nm, ".we"}, {31'd0, dmem_we}, {31'd0, v.e_we});
      chk({nm, ".be"}, {28'd0, dmem_be}, {28'd0, v.e_be});
      chk({nm, ".wdata"}, dmem_wdata, v.e_wdata);
      if (v.e_req) chk({nm, ".addr"}, dmem_addr, {v.alu[31:2], 2'b00});
      for (int i = 0; i < v.dly; i++) begin
         @(posedge clk); #1;
         chk({nm, ".bubble_en"}, {31'd0, rd0_wr_en_wb}, 32'd0);
         chk({nm, ".bubble_d"}, rd0_data_wb, 32'd0);
         @(negedge clk);
         if (i == v.dly - 1) begin
            dmem_ack = 1'b1; dmem_rdata = v.rdata;
         end
         #1;
         chk({nm, ".busy_req"}, {31'd0, dmem_req}, 32'd1);
         chk({nm, ".busy_stall"}, {31'd0, stall_ma}, {31'd0, (i != v.dly - 1)});
      end
      e.d = v.e_wbd; e.en = v.e_wbe; e.a = v.rd; e.chk_d = v.chk_d;
      sbq.push_back(e);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      e = sbq.pop_front();
      chk({nm, ".wb_en"}, {31'd0, rd0_wr_en_wb}, {31'd0, e.en});
      if (e.chk_d) begin
         chk({nm, ".wb_data"}, rd0_data_wb, e.d);
         chk({nm, ".wb_addr"}, {27'd0, rd0_addr_wb}, {27'd0, e.a});
      end
   endtask

   localparam int NV = 18;
   vec_t vt [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //          alu           rs2           rd wr f3      rwe rd     rdata         dly req we be       wdata         wbd           wbe chk
      vt[0]  = '{32'h100,      32'h0,        1, 0, 3'b010, 1, 5'd5,  32'hDEADBEEF, 0, 1, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 1, 1};
      vt[1]  = '{32'h103,      32'h0,        1, 0, 3'b000, 1, 5'd6,  32'h80112233, 3, 1, 0, 4'b1111, 32'h0,        32'hFFFFFF80, 1, 1};
      vt[2]  = '{32'h103,      32'h0,        1, 0, 3'b100, 1, 5'd6,  32'h80112233, 3, 1, 0, 4'b1111, 32'h0,        32'h00000080, 1, 1};
      vt[3]  = '{32'h202,      32'h0000ABCD, 0, 1, 3'b001, 0, 5'd0,  32'h0,        0, 1, 1, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0};
      vt[4]  = '{32'h1234,     32'h0,        0, 0, 3'b000, 1, 5'd7,  32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h1234,     1, 1};
      vt[5]  = '{32'h201,      32'h123456A5, 0, 1, 3'b000, 0, 5'd0,  32'h0,        1, 1, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0};
      vt[6]  = '{32'h300,      32'hCAFEF00D, 0, 1, 3'b010, 0, 5'd0,  32'h0,        0, 1, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 0};
      vt[7]  = '{32'h402,      32'h0,        1, 0, 3'b001, 1, 5'd9,  32'h80017FFF, 0, 1, 0, 4'b1111, 32'h0,        32'hFFFF8001, 1, 1};
      vt[8]  = '{32'h400,      32'h0,        1, 0, 3'b101, 1, 5'd10, 32'h8001F234, 2, 1, 0, 4'b1111, 32'h0,        32'h0000F234, 1, 1};
      vt[9]  = '{32'h400,      32'h0,        1, 0, 3'b001, 1, 5'd11, 32'h00007FFF, 0, 1, 0, 4'b1111, 32'h0,        32'h00007FFF, 1, 1};
      vt[10] = '{32'h101,      32'h0,        1, 0, 3'b000, 1, 5'd12, 32'h11227F44, 0, 1, 0, 4'b1111, 32'h0,        32'h0000007F, 1, 1};
      vt[11] = '{32'h102,      32'h0,        1, 0, 3'b000, 1, 5'd13, 32'h11AB3344, 0, 1, 0, 4'b1111, 32'h0,        32'hFFFFFFAB, 1, 1};
      vt[12] = '{32'h504,      32'h0,        1, 0, 3'b011, 1, 5'd14, 32'h12345678, 1, 1, 0, 4'b1111, 32'h0,        32'h12345678, 1, 1};
      vt[13] = '{32'h308,      32'h0F0F0F0F, 1, 1, 3'b010, 1, 5'd3,  32'h0,        0, 1, 1, 4'b1111, 32'h0F0F0F0F, 32'h0,        0, 0};
      vt[14] = '{32'h200,      32'h1234BEEF, 0, 1, 3'b001, 0, 5'd0,  32'h0,        0, 1, 1, 4'b0011, 32'hBEEFBEEF, 32'h0,        0, 0};
      vt[15] = '{32'h203,      32'h0000005A, 0, 1, 3'b000, 0, 5'd0,  32'h0,        0, 1, 1, 4'b1000, 32'h5A5A5A5A, 32'h0,        0, 0};
      vt[16] = '{32'h100,      32'h0,        1, 0, 3'b100, 0, 5'd15, 32'h000000FF, 0, 1, 0, 4'b1111, 32'h0,        32'h000000FF, 0, 1};
      vt[17] = '{32'h508,      32'h0,        1, 0, 3'b110, 1, 5'd16, 32'h89ABCDEF, 0, 1, 0, 4'b1111, 32'h0,        32'h89ABCDEF, 1, 1};

      // Reset state
      idle_inputs();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst.req", {31'd0, dmem_req}, 32'd0);
      chk("rst.stall", {31'd0, stall_ma}, 32'd0);
      chk("rst.wb_data", rd0_data_wb, 32'd0);
      chk("rst.wb_en", {31'd0, rd0_wr_en_wb}, 32'd0);
      chk("rst.wb_addr", {27'd0, rd0_addr_wb}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(vt[i], $sformatf("v%0d", i));

`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
      // Without the trap, low address bits are ignored for words and halves
      v = '{32'h102, 32'h0, 1, 0, 3'b010, 1, 5'd17, 32'hA1B2C3D4, 0, 1, 0, 4'b1111, 32'h0, 32'hA1B2C3D4, 1, 1};
      run_vec(v, "trunc_lw");
      v = '{32'h403, 32'h0, 1, 0, 3'b101, 1, 5'd18, 32'hBEEF0001, 0, 1, 0, 4'b1111, 32'h0, 32'h0000BEEF, 1, 1};
      run_vec(v, "trunc_lhu");
`endif

      // clk_en=0: no request from IDLE and the WB register holds
      v = '{32'h1234, 32'h0, 0, 0, 3'b000, 1, 5'd7, 32'h0, 0, 0, 0, 4'b0000, 32'h0, 32'h1234, 1, 1};
      run_vec(v, "pre_ce");
      @(negedge clk);
      idle_inputs();
      clk_en = 1'b0; data_rd_en_ma = 1'b1; alu_ma = 32'h800; rd0_wr_en_ma = 1'b1;
      rd0_addr_ma = 5'd2; funct3_ma = 3'b010;
      #1;
      chk("ce.req", {31'd0, dmem_req}, 32'd0);
      chk("ce.stall", {31'd0, stall_ma}, 32'd0);
      @(posedge clk); #1;
      chk("ce.wb_data", rd0_data_wb, 32'h1234);
      chk("ce.wb_en", {31'd0, rd0_wr_en_wb}, 32'd1);
      chk("ce.wb_addr", {27'd0, rd0_addr_wb}, 32'd7);

      // Flush on a zero-wait load clears WB instead of loading it
      @(negedge clk);
      idle_inputs();
      data_rd_en_ma = 1'b1; alu_ma = 32'h100; funct3_ma = 3'b010; rd0_wr_en_ma = 1'b1;
      rd0_addr_ma = 5'd4; dmem_ack = 1'b1; dmem_rdata = 32'h11111111; flush = 1'b1;
      #1;
      chk("fl0.req", {31'd0, dmem_req}, 32'd1);
      chk("fl0.stall", {31'd0, stall_ma}, 32'd0);
      @(posedge clk); #1;
      chk("fl0.wb_en", {31'd0, rd0_wr_en_wb}, 32'd0);
      chk("fl0.wb_data", rd0_data_wb, 32'd0);
      chk("fl0.wb_addr", {27'd0, rd0_addr_wb}, 32'd0);

      // Flush during BUSY keeps the request until ack, then clears WB
      @(negedge clk);
      idle_inputs();
      data_rd_en_ma = 1'b1; alu_ma = 32'h600; funct3_ma = 3'b010; rd0_wr_en_ma = 1'b1;
      rd0_addr_ma = 5'd8;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("fl1.req_busy", {31'd0, dmem_req}, 32'd1);
      chk("fl1.stall_busy", {31'd0, stall_ma}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("fl1.req_hold", {31'd0, dmem_req}, 32'd1);
      dmem_ack = 1'b1; dmem_rdata = 32'h00000055;
      @(posedge clk); #1;
      chk("fl1.wb_en", {31'd0, rd0_wr_en_wb}, 32'd0);
      chk("fl1.wb_data", rd0_data_wb, 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("fl1.idle_req", {31'd0, dmem_req}, 32'd0);

      // Reset with a valid WB value and a pending IDLE request
      run_vec(vt[4], "pre_rst");
      @(negedge clk);
      idle_inputs();
      data_rd_en_ma = 1'b1; alu_ma = 32'h700; funct3_ma = 3'b000;
      #2 rst_n = 1'b0;
      #1;
      chk("rst1.req", {31'd0, dmem_req}, 32'd0);
      chk("rst1.wb_data", rd0_data_wb, 32'd0);
      chk("rst1.wb_en", {31'd0, rd0_wr_en_wb}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Reset mid-BUSY drops the request at once and returns to IDLE
      @(posedge clk); #1;
      chk("rst2.busy_stall", {31'd0, stall_ma}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst2.req", {31'd0, dmem_req}, 32'd0);
      chk("rst2.stall", {31'd0, stall_ma}, 32'd0);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      #1;
      chk("rst2.idle_req", {31'd0, dmem_req}, 32'd0);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      // Misaligned word: no request, WB bubble, one-cycle error pulse
      @(negedge clk);
      idle_inputs();
      data_rd_en_ma = 1'b1; alu_ma = 32'h101; funct3_ma = 3'b010; rd0_wr_en_ma = 1'b1;
      rd0_addr_ma = 5'd5; dmem_ack = 1'b0;
      #1;
      chk("mis.req", {31'd0, dmem_req}, 32'd0);
      chk("mis.stall", {31'd0, stall_ma}, 32'd0);
      @(posedge clk); #1;
      chk("mis.err", {31'd0, misalign_err}, 32'd1);
      chk("mis.addr", misalign_addr, 32'h101);
      chk("mis.wb_en", {31'd0, rd0_wr_en_wb}, 32'd0);
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      chk("mis.err_pulse", {31'd0, misalign_err}, 32'd0);
      chk("mis.addr_hold", misalign_addr, 32'h101);
`endif

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
